cell_comm_link_stats: RTL

- Per-link Aurora receive-statistics block for N cell-communication links that share one Aurora user clock.
- Counts frames, CRC faults and channel-down events per link, using saturating counters.
- Provides atomic snapshot and clear, and a windowed CRC-fault-rate alarm.
- Sits between the Aurora link cores and the CSR readback path, and replaces the per-link ad-hoc CRC fault counters.

---
 rtl/cell_comm_stats_pkg.sv | 24 ++
 rtl/cell_comm_link_stats_if.sv | 31 +++
 rtl/cell_comm_link_counters.sv | 80 ++++++++
 rtl/cell_comm_link_stats.sv | 95 +++++++++
 4 files changed

// File: rtl/cell_comm_stats_pkg.sv
// Shared constants and helpers for the cell-communication link statistics block.
package cell_comm_stats_pkg;

    localparam int unsigned SAT_W = 64;
    localparam int unsigned CTL_W = 3;

    localparam int unsigned CTL_SNAP    = 0;
    localparam int unsigned CTL_CLR_CNT = 1;
    localparam int unsigned CTL_CLR_ALM = 2;

    localparam logic [1:0] CNT_FRAMES = 2'd0;
    localparam logic [1:0] CNT_CRC    = 2'd1;
    localparam logic [1:0] CNT_DOWN   = 2'd2;
    localparam logic [1:0] CNT_WIN    = 2'd3;

    // Increment by one when enabled, holding at max_v instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max_v,
                                                 input logic             en);
        if (en && (v != max_v)) return v + SAT_W'(1);
        return v;
    endfunction

endpackage

// File: rtl/cell_comm_link_stats_if.sv
// Aurora RX event, command and readback signals of the link statistics block.
interface cell_comm_link_stats_if #(
    parameter int unsigned NLINKS    = 2,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned WIN_WIDTH = 16
);
    logic [NLINKS-1:0]                       channelUp;
    logic [NLINKS-1:0]                       rxTvalid;
    logic [NLINKS-1:0]                       rxTlast;
    logic [NLINKS-1:0]                       rxCRCvalid;
    logic [NLINKS-1:0]                       rxCRCpass;
    logic                                    ctlStrobe;
    logic [cell_comm_stats_pkg::CTL_W-1:0]   ctlData;
    logic [WIN_WIDTH-1:0]                    alarmThreshold;
    logic [3:0]                              rdLink;
    logic [1:0]                              rdCounter;
    logic [CNT_WIDTH-1:0]                    rdData;
    logic [NLINKS-1:0]                       faultAlarm;

    modport master (
        output channelUp, rxTvalid, rxTlast, rxCRCvalid, rxCRCpass,
        output ctlStrobe, ctlData, alarmThreshold, rdLink, rdCounter,
        input  rdData, faultAlarm
    );

    modport slave (
        input  channelUp, rxTvalid, rxTlast, rxCRCvalid, rxCRCpass,
        input  ctlStrobe, ctlData, alarmThreshold, rdLink, rdCounter,
        output rdData, faultAlarm
    );
endinterface

// File: rtl/cell_comm_link_counters.sv
// One link: event decode, saturating live counters, window fault count and snapshot registers.
module cell_comm_link_counters
    import cell_comm_stats_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned WIN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 channel_up,
    input  logic                 rx_tvalid,
    input  logic                 rx_tlast,
    input  logic                 crc_valid,
    input  logic                 crc_pass,
    input  logic                 snap,
    input  logic                 clr,
    input  logic                 win_end,
    output logic [WIN_WIDTH-1:0] win_total_c,
    output logic [CNT_WIDTH-1:0] snap_frames,
    output logic [CNT_WIDTH-1:0] snap_crc,
    output logic [CNT_WIDTH-1:0] snap_down,
    output logic [WIN_WIDTH-1:0] snap_win
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIN_WIDTH-1:0] WIN_MAX = '1;

    logic                 up_prev;
    logic                 frame_c, fault_c, down_c;
    logic [CNT_WIDTH-1:0] frames, crcs, downs;
    logic [WIN_WIDTH-1:0] win_cnt, last_win;

    assign frame_c = rx_tvalid & rx_tlast;
    assign fault_c = crc_valid & ~crc_pass;
    assign down_c  = up_prev & ~channel_up;

    // Window count including this cycle's fault; becomes lastWindowFaults at window end.
    assign win_total_c = WIN_WIDTH'(sat_inc(SAT_W'(win_cnt), SAT_W'(WIN_MAX), fault_c));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_prev     <= 1'b0;
            frames      <= '0;
            crcs        <= '0;
            downs       <= '0;
            win_cnt     <= '0;
            last_win    <= '0;
            snap_frames <= '0;
            snap_crc    <= '0;
            snap_down   <= '0;
            snap_win    <= '0;
        end else begin
            up_prev <= channel_up;
            // Clear discards the events of its own cycle.
            if (clr) begin
                frames <= '0;
                crcs   <= '0;
                downs  <= '0;
            end else begin
                frames <= CNT_WIDTH'(sat_inc(SAT_W'(frames), SAT_W'(CNT_MAX), frame_c));
                crcs   <= CNT_WIDTH'(sat_inc(SAT_W'(crcs),   SAT_W'(CNT_MAX), fault_c));
                downs  <= CNT_WIDTH'(sat_inc(SAT_W'(downs),  SAT_W'(CNT_MAX), down_c));
            end
            if (win_end) begin
                last_win <= win_total_c;
                win_cnt  <= '0;
            end else begin
                win_cnt  <= win_total_c;
            end
            // Snapshot takes pre-update values, so the strobe-cycle event is excluded.
            if (snap) begin
                snap_frames <= frames;
                snap_crc    <= crcs;
                snap_down   <= downs;
                snap_win    <= last_win;
            end
        end
    end

endmodule

// File: rtl/cell_comm_link_stats.sv
// Per-link Aurora RX statistics: shared window timer, CRC-rate alarms and snapshot readback.
module cell_comm_link_stats
    import cell_comm_stats_pkg::*;
#(
    parameter int unsigned NLINKS        = 2,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned WIN_WIDTH     = 16,
    parameter int unsigned WINDOW_CYCLES = 125000000
) (
    input  logic                   auUserClk,
    input  logic                   auUserReset,
    cell_comm_link_stats_if.slave  bus
);

    localparam int unsigned         TIMER_W    = $clog2(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    logic [TIMER_W-1:0]   timer;
    logic                 win_end_c, snap_c, clr_cnt_c, clr_alm_c;
    logic [WIN_WIDTH-1:0] win_total_c [NLINKS];
    logic [CNT_WIDTH-1:0] snap_frames [NLINKS];
    logic [CNT_WIDTH-1:0] snap_crc    [NLINKS];
    logic [CNT_WIDTH-1:0] snap_down   [NLINKS];
    logic [WIN_WIDTH-1:0] snap_win    [NLINKS];
    logic [NLINKS-1:0]    alarm, alarm_nxt_c;
    logic [CNT_WIDTH-1:0] rd_data, rd_sel_c;

    assign win_end_c = (timer == TIMER_LAST);
    assign snap_c    = bus.ctlStrobe & bus.ctlData[CTL_SNAP];
    assign clr_cnt_c = bus.ctlStrobe & bus.ctlData[CTL_CLR_CNT];
    assign clr_alm_c = bus.ctlStrobe & bus.ctlData[CTL_CLR_ALM];

    for (genvar i = 0; i < NLINKS; i++) begin : g_link
        cell_comm_link_counters #(
            .CNT_WIDTH (CNT_WIDTH),
            .WIN_WIDTH (WIN_WIDTH)
        ) u_counters (
            .clk         (auUserClk),
            .rst         (auUserReset),
            .channel_up  (bus.channelUp[i]),
            .rx_tvalid   (bus.rxTvalid[i]),
            .rx_tlast    (bus.rxTlast[i]),
            .crc_valid   (bus.rxCRCvalid[i]),
            .crc_pass    (bus.rxCRCpass[i]),
            .snap        (snap_c),
            .clr         (clr_cnt_c),
            .win_end     (win_end_c),
            .win_total_c (win_total_c[i]),
            .snap_frames (snap_frames[i]),
            .snap_crc    (snap_crc[i]),
            .snap_down   (snap_down[i]),
            .snap_win    (snap_win[i])
        );
    end

    // Alarm set at window end takes priority over a same-cycle clear.
    always_comb begin
        alarm_nxt_c = clr_alm_c ? '0 : alarm;
        for (int i = 0; i < NLINKS; i++) begin
            if (win_end_c && (win_total_c[i] > bus.alarmThreshold)) alarm_nxt_c[i] = 1'b1;
        end
    end

    // Snapshot readback select; links beyond NLINKS read as zero.
    always_comb begin
        rd_sel_c = '0;
        for (int i = 0; i < NLINKS; i++) begin
            if (bus.rdLink == 4'(i)) begin
                case (bus.rdCounter)
                    CNT_FRAMES: rd_sel_c = snap_frames[i];
                    CNT_CRC:    rd_sel_c = snap_crc[i];
                    CNT_DOWN:   rd_sel_c = snap_down[i];
                    CNT_WIN:    rd_sel_c = CNT_WIDTH'(snap_win[i]);
                    default:    rd_sel_c = '0;
                endcase
            end
        end
    end

    always_ff @(posedge auUserClk or posedge auUserReset) begin
        if (auUserReset) begin
            timer   <= '0;
            alarm   <= '0;
            rd_data <= '0;
        end else begin
            timer   <= win_end_c ? '0 : timer + TIMER_W'(1);
            alarm   <= alarm_nxt_c;
            rd_data <= rd_sel_c;
        end
    end

    assign bus.rdData     = rd_data;
    assign bus.faultAlarm = alarm;

endmodule
